uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: i_clk cycles per UART bit; legal range 4..255; even values only.
REQ-002 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-003 i_rst  in  1  reset, asynchronous, active-low.
REQ-004 i_rx  in  1  serial line, asynchronous to i_clk, idle high; carries 8N1 frames (start low, 8 data bits LSB first, stop high).
REQ-005 i_ack  in  1  consumer acknowledge; clears o_valid.
REQ-006 o_data  out  8  last accepted byte; stable while o_valid is high.
REQ-007 o_valid  out  1  byte available; level signal held until acknowledged.
REQ-008 o_frame_err  out  1  one-cycle pulse when a stop bit samples low.
REQ-009 o_overrun  out  1  one-cycle pulse when a byte completes while o_valid is high and i_ack is low.
REQ-010 o_busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-011 i_rx passes through a 2-flop synchronizer (rx_s); the FSM uses only rx_s and a registered copy rx_prev.
REQ-012 FSM states: IDLE, START, DATA, STOP. Bit counter is 3 bits; clock counter is 8 bits.
REQ-013 IDLE: a falling edge (rx_prev=1, rx_s=0) enters START with clock counter = 0. A line that is already low never triggers.
REQ-014 START: at clock count CLKS_PER_BIT/2-1, rx_s=0 enters DATA with the counter cleared. rx_s=1 is a false start and returns to IDLE with no outputs.
REQ-015 DATA: rx_s is sampled when the clock counter reaches CLKS_PER_BIT-1 and shifted in LSB first. After bit 7 is sampled, the FSM enters STOP.
REQ-016 STOP: rx_s is sampled at count CLKS_PER_BIT-1, then the FSM goes to IDLE on the next edge.
- Stop=1 delivers the byte.
- Stop=0 pulses o_frame_err, discards the byte and leaves o_data/o_valid unchanged.
REQ-017 Byte delivery: o_data is loaded and o_valid set on the edge after the stop sample.
- Latency from the first i_clk edge that samples i_rx low to o_valid high is exactly 3 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles.
REQ-018 i_ack while o_valid=1 clears o_valid on the next edge. i_ack while o_valid=0 is ignored.
REQ-019 Delivery in the same cycle as i_ack: the new byte is loaded, o_valid stays 1 and there is no overrun.
REQ-020 Delivery while o_valid=1 and i_ack=0: o_overrun pulses and o_data keeps the old byte (new byte dropped).
REQ-021 The FSM returns to IDLE after STOP regardless of the stop value. A new frame is detected in the very next cycle if the line falls.

Reset
REQ-022 While i_rst=0: state=IDLE, counters=0, shift register=0.
REQ-023 While i_rst=0: o_data=8'h00, o_valid=0, o_frame_err=0, o_overrun=0, o_busy=0.
REQ-024 While i_rst=0: both synchronizer flops and rx_prev=1 (line idle), so releasing reset on a low line causes no false start.
REQ-025 Reset asserted mid-frame aborts the frame immediately. No partial byte is ever delivered.

Structure
REQ-026 Package uart_pkg holds:
- the rx state enum (IDLE/START/DATA/STOP, 2 bits);
- DATA_BITS=8;
- the default CLKS_PER_BIT.
uart_tx shares the same state encoding.
REQ-027 Sub-module sync_2ff (parameterized reset value, default 1) implements the synchronizer. The remaining logic is a single FSM process plus output registers.

Verification
REQ-028 CLKS_PER_BIT=16, frame 0xA5 with stop=1 -> o_valid rises exactly 3+8+144=155 cycles after the start edge, o_data=8'hA5, o_frame_err stays 0.
REQ-029 Low glitch on i_rx of 4 cycles -> returns to IDLE, o_valid=0, o_busy drops within 12 cycles.
REQ-030 Frame 0x3C with stop bit low -> single-cycle o_frame_err, o_valid=0, o_data unchanged (8'h00).
REQ-031 Frames 0x11 then 0x22 back-to-back with no i_ack -> o_overrun pulses once, o_data=8'h11. Repeat with i_ack on the 0x22 delivery cycle -> o_data=8'h22, no overrun.
REQ-032 i_rst pulsed low mid-DATA of 0x55, then frame 0x96 -> all outputs zero during reset, then o_data=8'h96 with a single o_valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, default bit timing and the FSM state
// encoding used by both receiver and transmitter.
package uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam int CLKS_PER_BIT_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; the reset value is
// the input's idle level so that leaving reset produces no spurious edge.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-edge detect, mid-bit sampling, and a level-valid
// output register with acknowledge, frame-error and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_rx,
  input  logic                 i_ack,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam logic [7:0] HALF_M1  = 8'(CLKS_PER_BIT/2 - 1);
  localparam logic [7:0] BIT_M1   = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] BIT_END  = 8'(CLKS_PER_BIT);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  logic rx_s;
  logic rx_prev_q;

  uart_state_e          state_q,   state_d;
  logic [7:0]           clk_cnt_q, clk_cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q,   shreg_d;
  logic                 stop_q,    stop_d;
  logic [DATA_BITS-1:0] data_q,    data_d;
  logic                 valid_q,   valid_d;
  logic                 ferr_q,    ferr_d;
  logic                 ovr_q,     ovr_d;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_d   (i_rx),
    .o_q   (rx_s)
  );

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    stop_d    = stop_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;

    if (i_ack && valid_q) valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          state_d   = ST_START;
          clk_cnt_d = '0;
        end
      end
      ST_START: begin
        if (clk_cnt_q == HALF_M1) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 8'd1;
        end
      end
      ST_DATA: begin
        if (clk_cnt_q == BIT_M1) begin
          clk_cnt_d = '0;
          shreg_d   = {rx_s, shreg_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == LAST_BIT) state_d = ST_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + 8'd1;
        end
      end
      ST_STOP: begin
        // Stop is sampled at BIT_M1; the extra count to BIT_END is the
        // delivery cycle so outputs update on the edge after the sample.
        if (clk_cnt_q == BIT_END) begin
          state_d   = ST_IDLE;
          clk_cnt_d = '0;
          if (!stop_q) begin
            ferr_d = 1'b1;
          end else if (!valid_q || i_ack) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end else begin
          if (clk_cnt_q == BIT_M1) stop_d = rx_s;
          clk_cnt_d = clk_cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rx_prev_q <= 1'b1;
      state_q   <= ST_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      stop_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_prev_q <= rx_s;
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      stop_q    <= stop_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_overrun   = ovr_q;
  assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: reset, latency, false start, frame error,
// overrun/ack interplay and mid-frame reset, with hand-computed expectations.
module tb_uart_rx;

  localparam int N = 16;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_rx  = 1'b1;
  logic       i_ack = 1'b0;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_rises = 0;
  int ovr_cnt = 0;
  int fe_cnt = 0;
  int fe_long = 0;
  int rise_cyc = 0;
  logic prev_valid = 1'b0;
  logic prev_fe = 1'b0;

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_rx        (i_rx),
    .i_ack       (i_ack),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Pulse/edge monitor sampled on the falling edge, away from updates.
  always @(negedge i_clk) begin
    if (o_valid && !prev_valid) begin
      valid_rises = valid_rises + 1;
      rise_cyc = cyc;
    end
    if (o_overrun) ovr_cnt = ovr_cnt + 1;
    if (o_frame_err) fe_cnt = fe_cnt + 1;
    if (o_frame_err && prev_fe) fe_long = fe_long + 1;
    prev_valid = o_valid;
    prev_fe = o_frame_err;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // ack_edge: index of the edge (0 = first edge seeing the start bit) at
  // which i_ack is held high; -1 for none.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int ack_edge);
    logic [9:0] bits;
    int k;
    bits = {stop, d, 1'b0};
    k = 0;
    for (int b = 0; b < 10; b++) begin
      i_rx = bits[b];
      for (int j = 0; j < N; j++) begin
        i_ack = (k == ack_edge);
        tick();
        k++;
      end
    end
    i_ack = 1'b0;
    i_rx = 1'b1;
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    i_rx = 1'b1;
    repeat (3) tick();
    checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", o_data); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    checks++; if (o_frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", o_frame_err); end
    checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b expected 0", o_overrun); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
    i_rst = 1'b1;
    repeat (4) tick();
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b expected 0", o_busy); end
  endtask

  task automatic test_frame_err();
    int fe0, fl0, v0;
    fe0 = fe_cnt; fl0 = fe_long; v0 = valid_rises;
    send_frame(8'h3C, 1'b0, -1);
    repeat (4) tick();
    checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL ferr_pulses: got %0d expected 1", fe_cnt - fe0); end
    checks++; if (fe_long != fl0) begin errors++; $display("FAIL ferr_width: got %0d multi-cycle expected 0", fe_long - fl0); end
    checks++; if (o_valid !== 1'b0 || valid_rises != v0) begin errors++; $display("FAIL ferr_valid: got %b expected 0", o_valid); end
    checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL ferr_data: got %h expected 00", o_data); end
  endtask

  task automatic test_glitch();
    int v0;
    v0 = valid_rises;
    i_rx = 1'b0;
    repeat (3) tick();
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_hi: got %b expected 1", o_busy); end
    tick();
    i_rx = 1'b1;
    repeat (8) tick();
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_lo: got %b expected 0", o_busy); end
    checks++; if (o_valid !== 1'b0 || valid_rises != v0) begin errors++; $display("FAIL glitch_valid: got %b expected 0", o_valid); end
    repeat (4) tick();
  endtask

  task automatic test_single_frame();
    int v0, fe0, start;
    v0 = valid_rises; fe0 = fe_cnt;
    start = cyc;
    send_frame(8'hA5, 1'b1, -1);
    repeat (2) tick();
    checks++; if (valid_rises - v0 != 1) begin errors++; $display("FAIL a5_rises: got %0d expected 1", valid_rises - v0); end
    checks++; if (rise_cyc - start - 1 != 155) begin errors++; $display("FAIL a5_latency: got %0d expected 155", rise_cyc - start - 1); end
    checks++; if (o_data !== 8'hA5) begin errors++; $display("FAIL a5_data: got %h expected a5", o_data); end
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL a5_valid: got %b expected 1", o_valid); end
    checks++; if (fe_cnt != fe0) begin errors++; $display("FAIL a5_ferr: got %0d pulses expected 0", fe_cnt - fe0); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL a5_busy: got %b expected 0", o_busy); end
  endtask

  task automatic test_ack();
    i_ack = 1'b1; tick(); i_ack = 1'b0;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL ack_clear: got %b expected 0", o_valid); end
    i_ack = 1'b1; tick(); i_ack = 1'b0; tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL ack_idle_valid: got %b expected 0", o_valid); end
    checks++; if (o_data !== 8'hA5) begin errors++; $display("FAIL ack_idle_data: got %h expected a5", o_data); end
  endtask

  task automatic test_back_to_back();
    int o0;
    o0 = ovr_cnt;
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, -1);
    tick();
    checks++; if (ovr_cnt - o0 != 1) begin errors++; $display("FAIL b2b_ovr: got %0d expected 1", ovr_cnt - o0); end
    checks++; if (o_data !== 8'h11) begin errors++; $display("FAIL b2b_data: got %h expected 11", o_data); end
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b expected 1", o_valid); end
    i_ack = 1'b1; tick(); i_ack = 1'b0;
    o0 = ovr_cnt;
    send_frame(8'h11, 1'b1, -1);
    send_frame(8'h22, 1'b1, 155);
    tick();
    checks++; if (ovr_cnt != o0) begin errors++; $display("FAIL b2b_ack_ovr: got %0d expected 0", ovr_cnt - o0); end
    checks++; if (o_data !== 8'h22) begin errors++; $display("FAIL b2b_ack_data: got %h expected 22", o_data); end
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL b2b_ack_valid: got %b expected 1", o_valid); end
  endtask

  task automatic test_reset_mid_frame();
    int v0;
    i_rx = 1'b0; repeat (N) tick();
    i_rx = 1'b1; repeat (N) tick();
    i_rx = 1'b0; repeat (N/2) tick();
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", o_busy); end
    i_rst = 1'b0;
    #2;
    checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL mid_rst_data: got %h expected 00", o_data); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", o_valid); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", o_busy); end
    checks++; if (o_frame_err !== 1'b0 || o_overrun !== 1'b0) begin errors++; $display("FAIL mid_rst_pulses: got %b%b expected 00", o_frame_err, o_overrun); end
    i_rx = 1'b1;
    repeat (3) tick();
    i_rst = 1'b1;
    v0 = valid_rises;
    repeat (20) tick();
    checks++; if (o_busy !== 1'b0 || valid_rises != v0) begin errors++; $display("FAIL mid_no_partial: busy %b rises %0d expected 0 0", o_busy, valid_rises - v0); end
    send_frame(8'h96, 1'b1, -1);
    tick();
    checks++; if (o_data !== 8'h96) begin errors++; $display("FAIL post_rst_data: got %h expected 96", o_data); end
    checks++; if (valid_rises - v0 != 1 || o_valid !== 1'b1) begin errors++; $display("FAIL post_rst_valid: rises %0d valid %b expected 1 1", valid_rises - v0, o_valid); end
  endtask

  initial begin
    test_reset();
    test_frame_err();
    test_glitch();
    test_single_frame();
    test_ack();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
